// File: rtl/phy_rx_pkg.sv
// Shared definitions for the receive-side PHY un-striper.
//   - FSM state encodings (2-bit)
//   - default lane count / word width / FIFO depth / skew limit
//   - clog2 helper, plus bits_for() which never returns a zero width
package phy_rx_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ALIGN = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_ERR   = 2'd3;

  localparam int LANES_DEF    = 2;
  localparam int WIDTH_DEF    = 32;
  localparam int DEPTH_DEF    = 4;
  localparam int SKEW_MAX_DEF = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  // Width for an index or counter over v values; at least one bit.
  function automatic int bits_for(input int v);
    return (v > 1) ? clog2(v) : 1;
  endfunction

endpackage

// File: rtl/un_byte_striping_n_lane_fifo.sv
// lane_fifo: per-lane synchronous deskew FIFO.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   i_push     write i_din (dropped when full unless popping this cycle)
//   i_pop      read the head word (ignored when empty)
//   i_flush    empty the FIFO; overrides push and pop
//   i_din      write data
//   o_dout     head word, valid when !o_empty
//   o_full     count == DEPTH
//   o_empty    count == 0
//   o_count    words held
module lane_fifo
  import phy_rx_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  logic [WIDTH-1:0]           i_din,
  output logic [WIDTH-1:0]           o_dout,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [clog2(DEPTH+1)-1:0]  o_count
);

  localparam int CW = clog2(DEPTH + 1);
  localparam int AW = bits_for(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd, r_wr;
  logic [CW-1:0]    r_count;
  logic             w_push, w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rd];

  assign w_pop  = i_pop && !o_empty;
  // A full FIFO still takes a word if the head leaves in the same cycle.
  assign w_push = i_push && (!o_full || w_pop);

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= nxt(r_wr);
      if (w_pop)  r_rd <= nxt(r_rd);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: emptiness is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr] <= i_din;
  end

endmodule

// File: rtl/un_byte_striping_n.sv
// un_byte_striping_n: receive-side un-striper for LANES lanes.
// Each lane is buffered in its own lane_fifo; once every lane holds a word
// the lanes are drained round-robin (0..LANES-1) onto one output stream.
// Ports:
//   clock, reset   clock, asynchronous active-high reset
//   lane_data      lane i word at [i*WIDTH +: WIDTH]
//   lane_valid     per-lane write strobe
//   clear_err      synchronous clear of the sticky error flags
//   data_out       registered merged word (held while valid_out=0)
//   valid_out      registered output strobe
//   err_pulse      one cycle high on entry to the error state
//   err_skew       sticky: lane alignment / stall timeout
//   err_overflow   sticky: a lane wrote into a full FIFO
module un_byte_striping_n
  import phy_rx_pkg::*;
#(
  parameter int LANES    = LANES_DEF,
  parameter int WIDTH    = WIDTH_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int SKEW_MAX = SKEW_MAX_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [LANES*WIDTH-1:0] lane_data,
  input  logic [LANES-1:0]       lane_valid,
  input  logic                   clear_err,
  output logic [WIDTH-1:0]       data_out,
  output logic                   valid_out,
  output logic                   err_pulse,
  output logic                   err_skew,
  output logic                   err_overflow
);

  localparam int PW   = bits_for(LANES);
  localparam int CNTW = bits_for(SKEW_MAX);
  localparam int FCW  = clog2(DEPTH + 1);

  logic [1:0]                   r_state, w_state_nxt;
  logic [PW-1:0]                r_ptr, w_ptr_nxt, w_ptr_inc, w_sel;
  logic [CNTW-1:0]              r_cnt, w_cnt_nxt;
  logic [LANES-1:0]             w_pop, w_full, w_empty, w_ovf;
  logic [LANES-1:0][WIDTH-1:0]  w_head;
  logic [LANES-1:0][FCW-1:0]    w_fcnt;
  logic                         w_flush, w_pop_en, w_all_ne, w_all_empty;
  logic                         w_timeout, w_enter_err;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk     (clock),
      .rst     (reset),
      .i_push  (lane_valid[g]),
      .i_pop   (w_pop[g]),
      .i_flush (w_flush),
      .i_din   (lane_data[g*WIDTH +: WIDTH]),
      .o_dout  (w_head[g]),
      .o_full  (w_full[g]),
      .o_empty (w_empty[g]),
      .o_count (w_fcnt[g])
    );
    assign w_pop[g] = w_pop_en && (w_sel == PW'(g));
    // Writes in the flush cycle are discarded, not counted as overflow.
    assign w_ovf[g] = lane_valid[g] && w_full[g] && !w_pop[g] && !w_flush;
  end

  assign w_all_ne    = &(~w_empty);
  assign w_all_empty = ~|w_fcnt;
  assign w_timeout   = (r_cnt == CNTW'(SKEW_MAX - 1));
  assign w_ptr_inc   = (r_ptr == PW'(LANES - 1)) ? '0 : r_ptr + 1'b1;
  assign w_enter_err = (w_state_nxt == ST_ERR) && (r_state != ST_ERR);

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_pop_en    = 1'b0;
    w_sel       = r_ptr;
    w_flush     = 1'b0;
    case (r_state)
      ST_IDLE, ST_ALIGN: begin
        if (w_all_ne) begin
          // Alignment reached: lane 0 goes out now, lane 1 is next.
          w_pop_en    = 1'b1;
          w_sel       = '0;
          w_ptr_nxt   = PW'(1);
          w_cnt_nxt   = '0;
          w_state_nxt = ST_RUN;
        end else if (r_state == ST_IDLE) begin
          if (!w_all_empty) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_ALIGN;
          end
        end else if (w_timeout) begin
          w_state_nxt = ST_ERR;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (!w_empty[r_ptr]) begin
          w_pop_en  = 1'b1;
          w_ptr_nxt = w_ptr_inc;
          w_cnt_nxt = '0;
        end else if (r_ptr == '0 && w_all_empty) begin
          // Round boundary with nothing buffered: stream has ended.
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else if (w_timeout) begin
          w_state_nxt = ST_ERR;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_flush     = 1'b1;
        w_ptr_nxt   = '0;
        w_cnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_ptr        <= '0;
      r_cnt        <= '0;
      data_out     <= '0;
      valid_out    <= 1'b0;
      err_pulse    <= 1'b0;
      err_skew     <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
      valid_out <= w_pop_en;
      if (w_pop_en) data_out <= w_head[w_sel];
      err_pulse    <= w_enter_err;
      // A new event in the same cycle as clear_err wins.
      err_skew     <= w_enter_err | (err_skew & ~clear_err);
      err_overflow <= (|w_ovf) | (err_overflow & ~clear_err);
    end
  end

endmodule

// File: tb/tb_un_byte_striping_n.sv
module tb_un_byte_striping_n;

  logic         clock = 1'b0;
  logic         reset = 1'b1;

  logic [63:0]  d2 = '0;
  logic [1:0]   v2 = '0;
  logic         c2 = 1'b0;
  logic [31:0]  o2;
  logic         vo2, p2, s2, ov2;

  logic [127:0] d4 = '0;
  logic [3:0]   v4 = '0;
  logic         c4 = 1'b0;
  logic [31:0]  o4;
  logic         vo4, p4, s4, ov4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  un_byte_striping_n #(.LANES(2), .WIDTH(32), .DEPTH(4), .SKEW_MAX(8)) u_dut2 (
    .clock(clock), .reset(reset), .lane_data(d2), .lane_valid(v2), .clear_err(c2),
    .data_out(o2), .valid_out(vo2), .err_pulse(p2), .err_skew(s2), .err_overflow(ov2));

  un_byte_striping_n #(.LANES(4), .WIDTH(32), .DEPTH(4), .SKEW_MAX(8)) u_dut4 (
    .clock(clock), .reset(reset), .lane_data(d4), .lane_valid(v4), .clear_err(c4),
    .data_out(o4), .valid_out(vo4), .err_pulse(p4), .err_skew(s4), .err_overflow(ov4));

  typedef struct {
    logic [1:0]  v;
    logic [31:0] d0, d1;
    logic        clr;
    logic        vo;
    logic [31:0] dout;
    logic        ps, sk, ov;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] hold;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  function automatic logic [31:0] w(input int sec, input int lane, input int k);
    return {8'h5A, 8'(sec), 8'(lane), 8'(k)};
  endfunction

  // Expected data_out follows the last valid word, so the builder tracks it.
  function void add(input logic [1:0] v, input logic [31:0] a, input logic [31:0] b,
                    input logic clr, input logic vo, input logic [31:0] wd,
                    input logic ps, input logic sk, input logic ov);
    vec_t r;
    if (vo) hold = wd;
    r.v = v; r.d0 = a; r.d1 = b; r.clr = clr; r.vo = vo; r.dout = hold;
    r.ps = ps; r.sk = sk; r.ov = ov;
    tbl.push_back(r);
  endfunction

  // Streams of N words per lane, lane i starting at step t[i]; expected
  // output is the lane-major interleave, contiguous, starting one step after
  // the latest lane's first write.
  task automatic rand_trial(input bit use4);
    int          L, N, tmax, nsteps, idx;
    int          t[4];
    logic [31:0] words[4][4];
    logic [31:0] exp_q[$];
    logic        vo, evo;
    logic [31:0] dout;
    L = use4 ? 4 : 2;
    N = int'($urandom_range(1, 4));
    tmax = 0;
    for (int i = 0; i < L; i++) begin
      t[i] = int'($urandom_range(0, 7));
      if (t[i] > tmax) tmax = t[i];
      for (int k = 0; k < N; k++) words[i][k] = $urandom;
    end
    for (int k = 0; k < N; k++)
      for (int i = 0; i < L; i++) exp_q.push_back(words[i][k]);
    nsteps = tmax + N * L + 4;
    for (int s = 0; s < nsteps; s++) begin
      for (int i = 0; i < L; i++) begin
        logic        vb;
        logic [31:0] db;
        vb = (s >= t[i]) && (s < t[i] + N);
        db = vb ? words[i][s - t[i]] : 32'h0;
        if (use4) begin v4[i] = vb; d4[i*32 +: 32] = db; end
        else      begin v2[i] = vb; d2[i*32 +: 32] = db; end
      end
      step();
      vo   = use4 ? vo4 : vo2;
      dout = use4 ? o4 : o2;
      idx  = s - tmax - 1;
      evo  = (idx >= 0) && (idx < N * L);
      chk($sformatf("rand L%0d s%0d valid_out", L, s), 64'(vo), 64'(evo));
      if (evo) chk($sformatf("rand L%0d word%0d data_out", L, idx), 64'(dout), 64'(exp_q[idx]));
    end
    chk($sformatf("rand L%0d errors", L), use4 ? 64'({p4, s4, ov4}) : 64'({p2, s2, ov2}), 64'(0));
    v2 = '0; d2 = '0; v4 = '0; d4 = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clock);
    chk("reset dut2 outputs", 64'({o2, vo2, p2, s2, ov2}), 64'(0));
    chk("reset dut4 outputs", 64'({o4, vo4, p4, s4, ov4}), 64'(0));
    reset = 1'b0;
    step();
    chk("post-reset dut2 idle", 64'({o2, vo2, p2, s2, ov2}), 64'(0));

    hold = '0;
    // Aligned two-word stream
    add(2'b11, w(1,0,0), w(1,1,0), 0, 0, 0, 0, 0, 0);
    add(2'b11, w(1,0,1), w(1,1,1), 0, 1, w(1,0,0), 0, 0, 0);
    add(2'b00, 0, 0, 0, 1, w(1,1,0), 0, 0, 0);
    add(2'b00, 0, 0, 0, 1, w(1,0,1), 0, 0, 0);
    add(2'b00, 0, 0, 0, 1, w(1,1,1), 0, 0, 0);
    add(2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    add(2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    // Lane 1 lags by 3 cycles, 4 words
    add(2'b01, w(2,0,0), 0, 0, 0, 0, 0, 0, 0);
    add(2'b01, w(2,0,1), 0, 0, 0, 0, 0, 0, 0);
    add(2'b01, w(2,0,2), 0, 0, 0, 0, 0, 0, 0);
    add(2'b11, w(2,0,3), w(2,1,0), 0, 0, 0, 0, 0, 0);
    add(2'b10, 0, w(2,1,1), 0, 1, w(2,0,0), 0, 0, 0);
    add(2'b10, 0, w(2,1,2), 0, 1, w(2,1,0), 0, 0, 0);
    add(2'b10, 0, w(2,1,3), 0, 1, w(2,0,1), 0, 0, 0);
    add(2'b00, 0, 0, 0, 1, w(2,1,1), 0, 0, 0);
    add(2'b00, 0, 0, 0, 1, w(2,0,2), 0, 0, 0);
    add(2'b00, 0, 0, 0, 1, w(2,1,2), 0, 0, 0);
    add(2'b00, 0, 0, 0, 1, w(2,0,3), 0, 0, 0);
    add(2'b00, 0, 0, 0, 1, w(2,1,3), 0, 0, 0);
    add(2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    add(2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    // Lane 1 silent past the skew limit -> timeout, flush, clear
    add(2'b01, w(3,0,0), 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) add(2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    add(2'b00, 0, 0, 0, 0, 0, 1, 1, 0);
    add(2'b00, 0, 0, 0, 0, 0, 0, 1, 0);
    add(2'b00, 0, 0, 1, 0, 0, 0, 0, 0);
    add(2'b11, w(3,0,1), w(3,1,1), 0, 0, 0, 0, 0, 0);
    add(2'b00, 0, 0, 0, 1, w(3,0,1), 0, 0, 0);
    add(2'b00, 0, 0, 0, 1, w(3,1,1), 0, 0, 0);
    add(2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    add(2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    // Lane 0 overflows on its fifth word; the fifth word is dropped
    for (int k = 0; k < 5; k++) add(2'b01, w(4,0,k), 0, 0, 0, 0, 0, 0, (k == 4));
    add(2'b10, 0, w(4,1,0), 0, 0, 0, 0, 0, 1);
    add(2'b10, 0, w(4,1,1), 0, 1, w(4,0,0), 0, 0, 1);
    add(2'b10, 0, w(4,1,2), 0, 1, w(4,1,0), 0, 0, 1);
    add(2'b10, 0, w(4,1,3), 0, 1, w(4,0,1), 0, 0, 1);
    add(2'b00, 0, 0, 0, 1, w(4,1,1), 0, 0, 1);
    add(2'b00, 0, 0, 0, 1, w(4,0,2), 0, 0, 1);
    add(2'b00, 0, 0, 0, 1, w(4,1,2), 0, 0, 1);
    add(2'b00, 0, 0, 0, 1, w(4,0,3), 0, 0, 1);
    add(2'b00, 0, 0, 0, 1, w(4,1,3), 0, 0, 1);
    add(2'b00, 0, 0, 0, 0, 0, 0, 0, 1);
    add(2'b00, 0, 0, 1, 0, 0, 0, 0, 0);
    add(2'b00, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int k = 0; k < tbl.size(); k++) begin
      v2 = tbl[k].v;
      d2 = {tbl[k].d1, tbl[k].d0};
      c2 = tbl[k].clr;
      step();
      chk($sformatf("tbl[%0d] {valid,pulse,skew,ovf}", k), 64'({vo2, p2, s2, ov2}),
          64'({tbl[k].vo, tbl[k].ps, tbl[k].sk, tbl[k].ov}));
      chk($sformatf("tbl[%0d] data_out", k), 64'(o2), 64'(tbl[k].dout));
    end
    v2 = '0; d2 = '0; c2 = 1'b0;

    // Reset in the middle of a RUN stream
    v2 = 2'b11; d2 = {w(5,1,0), w(5,0,0)}; step();
    v2 = 2'b11; d2 = {w(5,1,1), w(5,0,1)}; step();
    chk("midrun first word", 64'({vo2, o2}), 64'({1'b1, w(5,0,0)}));
    v2 = 2'b00; d2 = '0; step();
    chk("midrun second word", 64'({vo2, o2}), 64'({1'b1, w(5,1,0)}));
    #2 reset = 1'b1;
    #1 chk("async reset clears outputs", 64'({vo2, o2}), 64'(0));
    @(negedge clock);
    reset = 1'b0;
    v2 = 2'b11; d2 = {w(5,1,2), w(5,0,2)}; step();
    chk("post-reset no stale word", 64'(vo2), 64'(0));
    v2 = 2'b11; d2 = {w(5,1,3), w(5,0,3)}; step();
    chk("post-reset L0W0", 64'({vo2, o2}), 64'({1'b1, w(5,0,2)}));
    v2 = 2'b00; d2 = '0; step();
    chk("post-reset L1W0", 64'({vo2, o2}), 64'({1'b1, w(5,1,2)}));
    step();
    chk("post-reset L0W1", 64'({vo2, o2}), 64'({1'b1, w(5,0,3)}));
    step();
    chk("post-reset L1W1", 64'({vo2, o2}), 64'({1'b1, w(5,1,3)}));
    step();
    chk("post-reset end", 64'(vo2), 64'(0));
    step();

    // Four aligned lanes, two words each, then a fresh round from lane 0
    v4 = 4'hF; d4 = {w(6,3,0), w(6,2,0), w(6,1,0), w(6,0,0)}; step();
    chk("L4 first cycle idle", 64'(vo4), 64'(0));
    v4 = 4'hF; d4 = {w(6,3,1), w(6,2,1), w(6,1,1), w(6,0,1)}; step();
    v4 = '0; d4 = '0;
    for (int j = 0; j < 8; j++) begin
      if (j > 0) step();
      chk($sformatf("L4 out%0d", j), 64'({vo4, o4}), 64'({1'b1, w(6, j % 4, j / 4)}));
    end
    step();
    chk("L4 end of stream", 64'(vo4), 64'(0));
    v4 = 4'hF; d4 = {w(7,3,0), w(7,2,0), w(7,1,0), w(7,0,0)}; step();
    v4 = '0; d4 = '0;
    for (int j = 0; j < 4; j++) begin
      step();
      chk($sformatf("L4 round2 out%0d", j), 64'({vo4, o4}), 64'({1'b1, w(7, j, 0)}));
    end
    step();
    step();

    // Randomised skewed streams against the stream-level model
    for (int n = 0; n < 20; n++) rand_trial(1'b0);
    for (int n = 0; n < 20; n++) rand_trial(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
